fp_quant_issuer: RTL and testbench
==================================

// Module: fp_quant_issuer
// PURPOSE
//  AXI-stream initiator and result sink for the Multiply_Floating core (IEEE-754 single precision).
//  Accepts 8x8 DCT coefficients, pairs each with a reciprocal quantisation constant, and drives
//  operand channels A/B. It collects m_axis_result into a credit-guarded FIFO and emits
//  quantised coefficients with tlast once per block. Sits between the DCT stage and zig-zag/RLE.
// PARAMETERS
//  DATA_W      32  operand/result width (IEEE-754 single)
//  BLOCK_LEN   64  coefficients per block; tlast period; quant table depth
//  FIFO_DEPTH  16  result FIFO entries = max outstanding multiplies (power of 2)
// PORTS
//  aclk              in   1       clock, all logic rising edge
//  areset            in   1       synchronous reset, active high
//  s_coef_tvalid     in   1       coefficient valid
//  s_coef_tready     out  1       coefficient accepted when valid&ready
//  s_coef_tdata      in   32      DCT coefficient (float)
//  qt_we             in   1       quant-table write strobe
//  qt_addr           in   6       quant-table index
//  qt_wdata          in   32      reciprocal quant constant (float)
//  m_axis_a_tvalid   out  1       operand A valid -> multiplier s_axis_a_tvalid
//  m_axis_a_tready   in   1       multiplier s_axis_a_tready
//  m_axis_a_tdata    out  32      coefficient
//  m_axis_b_tvalid   out  1       operand B valid -> multiplier s_axis_b_tvalid
//  m_axis_b_tready   in   1       multiplier s_axis_b_tready
//  m_axis_b_tdata    out  32      qtable[idx]
//  s_result_tvalid   in   1       multiplier m_axis_result_tvalid (no backpressure available)
//  s_result_tdata    in   32      product
//  m_quant_tvalid/tready/tdata[32]/tlast  out/in/out/out  quantised output stream
//  busy              out  1       any op pending, in flight, or buffered
//  overflow          out  1       sticky: result arrived with FIFO full (dropped)
// BEHAVIOUR
//  Reset: all tvalid=0, tlast=0, busy=0, overflow=0, in_idx=out_idx=0, credits=FIFO_DEPTH,
//   FIFO empty, all qtable entries=32'h3F800000 (1.0). Reset mid-block abandons all state.
//  Issue FSM: IDLE -> ISSUE on coef accept; ISSUE -> IDLE when both A and B have handshaked.
//  s_coef_tready = (state==IDLE) & (credits!=0) & !areset.
//  On accept: latch A=coef, B=qtable[in_idx]; raise A/B tvalid next cycle; in_idx++ wraps BLOCK_LEN-1->0.
//  A and B are independent: each tvalid drops the cycle after its own handshake; data held stable
//   while valid. Neither is re-asserted before the next coef accept, so no duplicate operands.
//  Back-to-back ops: after ISSUE->IDLE, next accept is possible that cycle; 1 idle cycle/op max.
//  Credits: -1 on coef accept, +1 on output pop; both same cycle -> unchanged. Never <0 or >DEPTH.
//  Result FIFO: push on s_result_tvalid (1-cycle registered); first-word-fall-through to m_quant.
//   Push while full (only if multiplier misbehaves): drop, set overflow; cleared by reset only.
//   Push and pop same cycle when full: legal, no drop.
//  Output: m_quant_tlast = (out_idx==BLOCK_LEN-1); out_idx++ on pop, wraps to 0.
//  Qtable write: any time; takes effect for accepts from the next cycle. Same-cycle write and
//   capture of same index -> old value captured.
//  busy = (state!=IDLE) | (credits!=FIFO_DEPTH).
// CONFIGURATION
//  FPQ_FLUSH_DENORM_EN defined: FIFO output with exponent==0 (zero/denormal) -> 32'h00000000
//   (sign cleared), so -0.0 never leaves the block. Undefined: results pass bit-exact.
// TESTING (bench models Multiply_Floating, latency L=6, random tready unless noted)
//  1 default table, coef 0x420A3D71 (34.56) -> m_quant 0x420A3D71, tlast=0, overflow=0.
//  2 qt[0]=0x41F5EB85 (30.74), coef 34.56 -> ~0x4484CBFB (1062.37, +-1ulp vs bench FP model).
//  3 stream 130 coefs -> tlast only on outputs #64 and #128; output order equals input order.
//  4 m_quant_tready=0: exactly 16 coefs accepted, then s_coef_tready=0; release -> no loss/dup.
//  5 a_tready at cycle n, b_tready at n+3 -> one product, A/B tvalid each drop once.
//  6 areset at coef #30 -> all valids 0 next cycle, restart from #0 gives tlast at #64;
//    with FPQ_FLUSH_DENORM_EN, coef 0x80000000 -> 0x00000000 (without it, 0x80000000).

Source files
------------

// File: rtl/fp_quant_issuer_if.sv
// Stream bundle between fp_quant_issuer and its neighbours: coefficient in,
// quant-table write port, multiplier operand/result channels and quantised output.
interface fp_quant_issuer_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 6
);
    logic              s_coef_tvalid;
    logic              s_coef_tready;
    logic [DATA_W-1:0] s_coef_tdata;
    logic              qt_we;
    logic [AW-1:0]     qt_addr;
    logic [DATA_W-1:0] qt_wdata;
    logic              m_axis_a_tvalid;
    logic              m_axis_a_tready;
    logic [DATA_W-1:0] m_axis_a_tdata;
    logic              m_axis_b_tvalid;
    logic              m_axis_b_tready;
    logic [DATA_W-1:0] m_axis_b_tdata;
    logic              s_result_tvalid;
    logic [DATA_W-1:0] s_result_tdata;
    logic              m_quant_tvalid;
    logic              m_quant_tready;
    logic [DATA_W-1:0] m_quant_tdata;
    logic              m_quant_tlast;
    logic              busy;
    logic              overflow;

    modport master (
        input  s_coef_tvalid, s_coef_tdata,
        input  qt_we, qt_addr, qt_wdata,
        input  m_axis_a_tready, m_axis_b_tready,
        input  s_result_tvalid, s_result_tdata,
        input  m_quant_tready,
        output s_coef_tready,
        output m_axis_a_tvalid, m_axis_a_tdata,
        output m_axis_b_tvalid, m_axis_b_tdata,
        output m_quant_tvalid, m_quant_tdata, m_quant_tlast,
        output busy, overflow
    );

    modport slave (
        output s_coef_tvalid, s_coef_tdata,
        output qt_we, qt_addr, qt_wdata,
        output m_axis_a_tready, m_axis_b_tready,
        output s_result_tvalid, s_result_tdata,
        output m_quant_tready,
        input  s_coef_tready,
        input  m_axis_a_tvalid, m_axis_a_tdata,
        input  m_axis_b_tvalid, m_axis_b_tdata,
        input  m_quant_tvalid, m_quant_tdata, m_quant_tlast,
        input  busy, overflow
    );
endinterface

// File: rtl/fp_quant_issuer.sv
// Issues coefficient x reciprocal-quant operand pairs to a float multiplier and
// buffers the products in a credit-guarded FWFT FIFO. Option: FPQ_FLUSH_DENORM_EN.
module fp_quant_issuer #(
    parameter int DATA_W     = 32,
    parameter int BLOCK_LEN  = 64,
    parameter int FIFO_DEPTH = 16
) (
    input logic              aclk,
    input logic              areset,
    fp_quant_issuer_if.master bus
);
    localparam int IW = $clog2(BLOCK_LEN);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(32'h3F80_0000);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state_q, state_d;
    logic              a_vld_q, a_vld_d;
    logic              b_vld_q, b_vld_d;
    logic [DATA_W-1:0] a_dat_q, a_dat_d;
    logic [DATA_W-1:0] b_dat_q, b_dat_d;
    logic [IW-1:0]     in_idx_q, in_idx_d;
    logic [IW-1:0]     out_idx_q, out_idx_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic [DATA_W-1:0] qtable_q [BLOCK_LEN];
    logic [DATA_W-1:0] qtable_d [BLOCK_LEN];
    logic              res_vld_q, res_vld_d;
    logic [DATA_W-1:0] res_dat_q, res_dat_d;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              coef_acc;
    logic              a_hs;
    logic              b_hs;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic [DATA_W-1:0] head;

    assign bus.s_coef_tready = (state_q == IDLE) && (credits_q != '0) && !areset;
    assign coef_acc = bus.s_coef_tvalid && bus.s_coef_tready;
    assign a_hs     = a_vld_q && bus.m_axis_a_tready;
    assign b_hs     = b_vld_q && bus.m_axis_b_tready;
    assign pop      = (cnt_q != '0) && bus.m_quant_tready;
    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    // a full FIFO still takes a push when the head leaves the same cycle
    assign push_ok  = res_vld_q && (!full || pop);

    always_comb begin
        state_d  = state_q;
        a_vld_d  = a_vld_q;
        b_vld_d  = b_vld_q;
        a_dat_d  = a_dat_q;
        b_dat_d  = b_dat_q;
        in_idx_d = in_idx_q;
        unique case (state_q)
            IDLE: begin
                if (coef_acc) begin
                    state_d  = ISSUE;
                    a_vld_d  = 1'b1;
                    b_vld_d  = 1'b1;
                    a_dat_d  = bus.s_coef_tdata;
                    b_dat_d  = qtable_q[in_idx_q];
                    in_idx_d = (in_idx_q == IW'(BLOCK_LEN - 1)) ? '0 : in_idx_q + 1'b1;
                end
            end
            ISSUE: begin
                if (a_hs) a_vld_d = 1'b0;
                if (b_hs) b_vld_d = 1'b0;
                if (!a_vld_d && !b_vld_d) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        qtable_d = qtable_q;
        if (bus.qt_we) qtable_d[bus.qt_addr] = bus.qt_wdata;
        credits_d = credits_q;
        unique case ({coef_acc, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        res_vld_d  = bus.s_result_tvalid;
        res_dat_d  = bus.s_result_tdata;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        out_idx_d  = out_idx_q;
        ovf_d      = ovf_q || (res_vld_q && !push_ok);
        if (push_ok) begin
            fifo_mem_d[wr_ptr_q] = res_dat_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            out_idx_d = (out_idx_q == IW'(BLOCK_LEN - 1)) ? '0 : out_idx_q + 1'b1;
        end
        unique case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            a_vld_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            a_dat_q   <= '0;
            b_dat_q   <= '0;
            in_idx_q  <= '0;
            out_idx_q <= '0;
            credits_q <= CW'(FIFO_DEPTH);
            res_vld_q <= 1'b0;
            res_dat_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < BLOCK_LEN; i++) qtable_q[i] <= ONE;
        end else begin
            state_q   <= state_d;
            a_vld_q   <= a_vld_d;
            b_vld_q   <= b_vld_d;
            a_dat_q   <= a_dat_d;
            b_dat_q   <= b_dat_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            credits_q <= credits_d;
            res_vld_q <= res_vld_d;
            res_dat_q <= res_dat_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            qtable_q  <= qtable_d;
        end
    end

    // storage only; occupancy is tracked by the reset pointers
    always_ff @(posedge aclk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign head = fifo_mem_q[rd_ptr_q];

`ifdef FPQ_FLUSH_DENORM_EN
    assign bus.m_quant_tdata = (head[30:23] == 8'd0) ? '0 : head;
`else
    assign bus.m_quant_tdata = head;
`endif

    assign bus.m_axis_a_tvalid = a_vld_q;
    assign bus.m_axis_a_tdata  = a_dat_q;
    assign bus.m_axis_b_tvalid = b_vld_q;
    assign bus.m_axis_b_tdata  = b_dat_q;
    assign bus.m_quant_tvalid  = (cnt_q != '0);
    assign bus.m_quant_tlast   = (out_idx_q == IW'(BLOCK_LEN - 1));
    assign bus.busy            = (state_q != IDLE) || (credits_q != CW'(FIFO_DEPTH));
    assign bus.overflow        = ovf_q;
endmodule

// File: tb/tb_fp_quant_issuer.sv
// Bench for fp_quant_issuer with a latency-6 float multiplier model and an
// output scoreboard; vector table plus hand-written corner sequences.
module tb_fp_quant_issuer;
    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    fp_quant_issuer_if #(.DATA_W(32), .AW(6)) bus ();

    fp_quant_issuer #(
        .DATA_W(32), .BLOCK_LEN(64), .FIFO_DEPTH(16)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus.master)
    );

    typedef struct {
        logic [31:0] d;
        int          tol;
    } exp_t;

    typedef struct {
        logic [31:0] coef;
        logic [31:0] qt;
        logic [31:0] exp;
        int          tol;
    } vec_t;

    int          n_chk;
    int          n_pass;
    logic [31:0] coef_q[$];
    exp_t        sb[$];
    logic [31:0] qt_m[64];
    int          in_idx_m;
    int          out_cnt_m;
    int          acc_cnt;
    int          a_hs_cnt;
    int          b_hs_cnt;
    int          tlast_seen;
    logic        a_have;
    logic        b_have;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        pv[6];
    logic [31:0] pd[6];
    bit          rnd_rdy;
    bit          rnd_qt;
    int          q_mode;
    bit          use_tab;
    logic [31:0] tab_exp;
    int          tab_tol;
    vec_t        tab[6];

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [22:0] m;
        logic        g;
        logic        st;
        logic [24:0] r;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24]; g = p[23]; st = |p[22:0]; e++;
        end else begin
            m = p[45:23]; g = p[22]; st = |p[21:0];
        end
        r = {2'b01, m} + 25'(g & (st | m[0]));
        if (r[24]) begin
            e++;
            r = r >> 1;
        end
        return {s, e[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fexp(input logic [31:0] c, input logic [31:0] q);
        logic [31:0] r;
        r = fmul(c, q);
`ifdef FPQ_FLUSH_DENORM_EN
        if (r[30:23] == 8'd0) r = 32'h0;
`endif
        return r;
    endfunction

    function automatic logic [31:0] rnd_float(input int lo, input int hi);
        logic [7:0] e;
        e = 8'($urandom_range(lo, hi));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic chk(input string nm, input longint act, input longint req, input int tol);
        longint d;
        n_chk++;
        d = act - req;
        if (d < 0) d = -d;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, req);
    endtask

    task automatic clear_model();
        coef_q.delete();
        sb.delete();
        for (int i = 0; i < 64; i++) qt_m[i] = 32'h3F80_0000;
        for (int i = 0; i < 6; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        in_idx_m = 0; out_cnt_m = 0; acc_cnt = 0;
        a_hs_cnt = 0; b_hs_cnt = 0; tlast_seen = 0;
        a_have = 1'b0; b_have = 1'b0;
        bus.s_coef_tvalid   = 1'b0;
        bus.s_coef_tdata    = '0;
        bus.qt_we           = 1'b0;
        bus.qt_addr         = '0;
        bus.qt_wdata        = '0;
        bus.s_result_tvalid = 1'b0;
        bus.s_result_tdata  = '0;
        bus.m_axis_a_tready = 1'b0;
        bus.m_axis_b_tready = 1'b0;
        bus.m_quant_tready  = 1'b0;
    endtask

    task automatic cycle();
        logic        cf, af, bf, qf, ql;
        logic [31:0] cd, ad, bd, qd;
        exp_t        e;
        @(negedge aclk);
        cf = bus.s_coef_tvalid && bus.s_coef_tready;
        af = bus.m_axis_a_tvalid && bus.m_axis_a_tready;
        bf = bus.m_axis_b_tvalid && bus.m_axis_b_tready;
        qf = bus.m_quant_tvalid && bus.m_quant_tready;
        cd = bus.s_coef_tdata;
        ad = bus.m_axis_a_tdata;
        bd = bus.m_axis_b_tdata;
        qd = bus.m_quant_tdata;
        ql = bus.m_quant_tlast;
        @(posedge aclk);
        #1;
        if (cf) begin
            acc_cnt++;
            if (use_tab) sb.push_back('{tab_exp, tab_tol});
            else sb.push_back('{fexp(cd, qt_m[in_idx_m]), 0});
            in_idx_m = (in_idx_m + 1) % 64;
            void'(coef_q.pop_front());
        end
        if (bus.qt_we) qt_m[bus.qt_addr] = bus.qt_wdata;
        bus.qt_we = 1'b0;
        for (int i = 5; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = 1'b0;
        if (af) begin
            mul_a = ad; a_have = 1'b1; a_hs_cnt++;
        end
        if (bf) begin
            mul_b = bd; b_have = 1'b1; b_hs_cnt++;
        end
        if (a_have && b_have) begin
            pv[0] = 1'b1;
            pd[0] = fmul(mul_a, mul_b);
            a_have = 1'b0;
            b_have = 1'b0;
        end
        bus.s_result_tvalid = pv[5];
        bus.s_result_tdata  = pd[5];
        if (qf) begin
            if (ql) tlast_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_output", qd, 0, -1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("out%0d_data", out_cnt_m), qd, e.d, e.tol);
                chk($sformatf("out%0d_tlast", out_cnt_m), ql, (out_cnt_m % 64) == 63, 0);
            end
            out_cnt_m++;
        end
        bus.s_coef_tvalid = coef_q.size() != 0;
        bus.s_coef_tdata  = (coef_q.size() != 0) ? coef_q[0] : '0;
        if (rnd_rdy) begin
            bus.m_axis_a_tready = 1'($urandom_range(0, 1)) && !a_have;
            bus.m_axis_b_tready = 1'($urandom_range(0, 1)) && !b_have;
        end
        if (rnd_qt && $urandom_range(0, 7) == 0) begin
            bus.qt_we    = 1'b1;
            bus.qt_addr  = 6'($urandom_range(0, 63));
            bus.qt_wdata = rnd_float(115, 130);
        end
        unique case (q_mode)
            0:       bus.m_quant_tready = $urandom_range(0, 3) != 0;
            1:       bus.m_quant_tready = 1'b0;
            default: bus.m_quant_tready = 1'b1;
        endcase
        #1;
    endtask

    task automatic do_reset(input bit check);
        areset = 1'b1;
        bus.s_coef_tvalid   = 1'b0;
        bus.s_result_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        if (check) begin
            chk("rst_a_tvalid", bus.m_axis_a_tvalid, 0, 0);
            chk("rst_b_tvalid", bus.m_axis_b_tvalid, 0, 0);
            chk("rst_q_tvalid", bus.m_quant_tvalid, 0, 0);
            chk("rst_tlast", bus.m_quant_tlast, 0, 0);
            chk("rst_busy", bus.busy, 0, 0);
            chk("rst_overflow", bus.overflow, 0, 0);
            chk("rst_coef_tready", bus.s_coef_tready, 0, 0);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        clear_model();
        #1;
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((coef_q.size() != 0 || sb.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        n_chk++;
        if (n < budget) n_pass++;
        else $display("FAIL %s_timeout: pending %0d required 0", nm, sb.size() + coef_q.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_chk = 0; n_pass = 0;
        rnd_rdy = 1'b1; rnd_qt = 1'b0; q_mode = 0;
        use_tab = 1'b0; tab_exp = '0; tab_tol = 0;
        clear_model();
        areset = 1'b1;

        tab[0] = '{32'h420A_3D71, 32'h3F80_0000, 32'h420A_3D71, 0};
        tab[1] = '{32'h420A_3D71, 32'h41F5_EB85, 32'h4484_CBFB, 1};
        tab[2] = '{32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, 0};
        tab[3] = '{32'hC040_0000, 32'h3E80_0000, 32'hBF40_0000, 0};
        tab[4] = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 0};
`ifdef FPQ_FLUSH_DENORM_EN
        tab[5] = '{32'h8000_0000, 32'h3F80_0000, 32'h0000_0000, 0};
`else
        tab[5] = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 0};
`endif

        do_reset(1'b1);
        chk("idle_coef_tready", bus.s_coef_tready, 1, 0);
        chk("idle_busy", bus.busy, 0, 0);

        foreach (tab[i]) begin
            do_reset(1'b0);
            if (tab[i].qt != 32'h3F80_0000) begin
                bus.qt_we = 1'b1; bus.qt_addr = '0; bus.qt_wdata = tab[i].qt;
                cycle();
            end
            use_tab = 1'b1;
            tab_exp = tab[i].exp;
            tab_tol = tab[i].tol;
            coef_q.push_back(tab[i].coef);
            drain($sformatf("vec%0d", i), 200);
            use_tab = 1'b0;
            chk($sformatf("vec%0d_overflow", i), bus.overflow, 0, 0);
        end

        // same-cycle table write and capture of the same index
        do_reset(1'b0);
        rnd_rdy = 1'b1; q_mode = 2;
        coef_q.push_back(32'h4040_0000);
        bus.s_coef_tvalid = 1'b1; bus.s_coef_tdata = 32'h4040_0000;
        bus.qt_we = 1'b1; bus.qt_addr = '0; bus.qt_wdata = 32'h4000_0000;
        cycle();
        coef_q.push_back(32'h4040_0000);
        drain("qt_race", 200);
        chk("qt_race_second_idx1", qt_m[0], 32'h4000_0000, 0);

        // long random stream with random table writes
        do_reset(1'b0);
        rnd_rdy = 1'b1; q_mode = 0; rnd_qt = 1'b1;
        for (int i = 0; i < 130; i++) coef_q.push_back(rnd_float(110, 140));
        drain("stream130", 8000);
        rnd_qt = 1'b0;
        chk("stream130_count", out_cnt_m, 130, 0);
        chk("stream130_tlasts", tlast_seen, 2, 0);
        chk("stream130_busy", bus.busy, 0, 0);
        chk("stream130_overflow", bus.overflow, 0, 0);

        // output backpressure: credits stop the issuer at FIFO depth
        do_reset(1'b0);
        rnd_rdy = 1'b1; q_mode = 1;
        for (int i = 0; i < 20; i++) coef_q.push_back(rnd_float(110, 140));
        for (int i = 0; i < 200; i++) cycle();
        chk("bp_accepted", acc_cnt, 16, 0);
        chk("bp_coef_tready", bus.s_coef_tready, 0, 0);
        chk("bp_busy", bus.busy, 1, 0);
        chk("bp_q_tvalid", bus.m_quant_tvalid, 1, 0);
        q_mode = 2;
        drain("bp_release", 1000);
        chk("bp_total", out_cnt_m, 20, 0);
        chk("bp_overflow", bus.overflow, 0, 0);

        // A at cycle n, B at n+3
        do_reset(1'b0);
        rnd_rdy = 1'b0; q_mode = 2;
        coef_q.push_back(32'h4120_0000);
        n = 0;
        while (!bus.m_axis_a_tvalid && n < 20) begin
            cycle();
            n++;
        end
        chk("ab_a_raised", bus.m_axis_a_tvalid, 1, 0);
        bus.m_axis_a_tready = 1'b1;
        cycle();
        bus.m_axis_a_tready = 1'b0;
        chk("ab_a_dropped", bus.m_axis_a_tvalid, 0, 0);
        chk("ab_b_held", bus.m_axis_b_tvalid, 1, 0);
        cycle();
        cycle();
        chk("ab_a_stays_low", bus.m_axis_a_tvalid, 0, 0);
        chk("ab_busy", bus.busy, 1, 0);
        bus.m_axis_b_tready = 1'b1;
        cycle();
        bus.m_axis_b_tready = 1'b0;
        chk("ab_b_dropped", bus.m_axis_b_tvalid, 0, 0);
        drain("ab_split", 200);
        chk("ab_a_count", a_hs_cnt, 1, 0);
        chk("ab_b_count", b_hs_cnt, 1, 0);
        chk("ab_outputs", out_cnt_m, 1, 0);

        // reset mid-block then a full block from index 0
        do_reset(1'b0);
        rnd_rdy = 1'b1; q_mode = 0;
        for (int i = 0; i < 64; i++) coef_q.push_back(rnd_float(110, 140));
        n = 0;
        while (acc_cnt < 30 && n < 2000) begin
            cycle();
            n++;
        end
        chk("mid_reached30", acc_cnt, 30, 0);
        do_reset(1'b1);
        rnd_rdy = 1'b1; q_mode = 0;
        for (int i = 0; i < 64; i++) coef_q.push_back(rnd_float(110, 140));
        drain("restart64", 5000);
        chk("restart64_tlasts", tlast_seen, 1, 0);
        chk("restart64_count", out_cnt_m, 64, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
